// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: opcodes,
// FSM state type and the datapath mux/ALU select encodings.
// Optional feature macro: MCCTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        JAL,
        ALUWB,
        BEQ
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } statetype;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the controller's ALUOp plus funct fields onto the
// 3-bit ALU function select.
module aludec
    import riscv_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    // Subtract only for R-type with bit 30 set; addi ignores bit 30
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: Moore FSM sequencing fetch/decode/execute/memory/
// writeback over a shared datapath, stalling on MemReady.
// Optional feature macro: MCCTRL_ILLEGAL_TRAP_EN (sticky Illegal flag, TRAP state).
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    output logic       Illegal
`endif
);

    statetype   state;
    statetype   next_state;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_state;

    // State register; reset aborts any instruction and restarts at FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Next-state and per-state datapath controls, all defaults first
    always_comb begin
        next_state    = state;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        illegal_state = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        case (state)
            FETCH: begin
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                ir_write_raw = MemReady;
                pc_update    = MemReady;
                next_state   = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTER;
                    OP_ITYPE:     next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    OP_BEQ:       next_state = (funct3 == 3'b000) ? BEQ : TRAP;
                    default:      next_state = TRAP;
`else
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                next_state    = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                next_state = FETCH;
            end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal_state = 1'b1;
                next_state    = TRAP;
            end
`endif
            default: next_state = FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // Architectural write enables are held off for as long as reset is high
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign RegWrite = ~reset & reg_write_raw;

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign Illegal = illegal_state;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_state;
`endif

    aludec u_aludec (
        .opb5        (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (alu_op),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: drives per-cycle opcode/
// flag vectors and compares the packed control outputs to hand-derived values.
// Honours MCCTRL_ILLEGAL_TRAP_EN for the Illegal port and trap sequence.
module tb_multicycle_controller;

    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_BEQ  = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_BAD  = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    logic       Illegal;
`endif

    int compare_count = 0;
    int fail_count    = 0;

    logic [15:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, RegWrite};

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite)
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        ,
        .Illegal    (Illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs expected control values in the same order as obs
    function automatic logic [15:0] ex(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic rw);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw};
    endfunction

    function automatic logic [15:0] fetchOk(input logic [1:0] imm);
        return ex(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [15:0] fetchWait(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [15:0] decodeExp(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic rdy);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        MemReady = rdy;
        #1;
    endtask

    // One clock cycle: drive, compare the combinational outputs, then step
    task automatic cycleCheck(input string tag, input logic [6:0] o,
                              input logic [2:0] f3, input logic f7, input logic z,
                              input logic rdy, input logic [15:0] expected);
        applyStimulus(o, f3, f7, z, rdy);
        checkOutput(tag, {16'h0, obs}, {16'h0, expected});
        @(posedge clk);
        #1;
    endtask

    logic [2:0] r_f3   [6] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
    logic       r_f7   [6] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
    logic [2:0] r_alu  [6] = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000};

    initial begin
        reset = 1'b0;
        applyStimulus(7'b0, 3'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("reset_fetch_gated", {16'h0, obs}, {16'h0, fetchWait(2'b00)});
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // R-type: add, sub, slt, or, and, unsupported funct3
        for (int i = 0; i < 6; i++) begin
            cycleCheck($sformatf("r%0d_fetch", i), T_R, r_f3[i], r_f7[i], 1'b0, 1'b1, fetchOk(2'b00));
            cycleCheck($sformatf("r%0d_decode", i), T_R, r_f3[i], r_f7[i], 1'b0, 1'b1, decodeExp(2'b00));
            cycleCheck($sformatf("r%0d_exec", i), T_R, r_f3[i], r_f7[i], 1'b0, 1'b1,
                       ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, r_alu[i], 1'b0));
            cycleCheck($sformatf("r%0d_wb", i), T_R, r_f3[i], r_f7[i], 1'b0, 1'b1,
                       ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
        end

        // addi with bit 30 set still adds; fetch stalls one cycle first
        cycleCheck("addi_fetch_wait", T_I, 3'b000, 1'b1, 1'b0, 1'b0, fetchWait(2'b00));
        cycleCheck("addi_fetch", T_I, 3'b000, 1'b1, 1'b0, 1'b1, fetchOk(2'b00));
        cycleCheck("addi_decode", T_I, 3'b000, 1'b1, 1'b0, 1'b1, decodeExp(2'b00));
        cycleCheck("addi_exec", T_I, 3'b000, 1'b1, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        cycleCheck("addi_wb", T_I, 3'b000, 1'b1, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // ori
        cycleCheck("ori_fetch", T_I, 3'b110, 1'b0, 1'b0, 1'b1, fetchOk(2'b00));
        cycleCheck("ori_decode", T_I, 3'b110, 1'b0, 1'b0, 1'b1, decodeExp(2'b00));
        cycleCheck("ori_exec", T_I, 3'b110, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 1'b0));
        cycleCheck("ori_wb", T_I, 3'b110, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // lw with two wait states in MEMREAD: 7 cycles
        cycleCheck("lw_fetch", T_LW, 3'b010, 1'b0, 1'b0, 1'b1, fetchOk(2'b00));
        cycleCheck("lw_decode", T_LW, 3'b010, 1'b0, 1'b0, 1'b1, decodeExp(2'b00));
        cycleCheck("lw_memadr", T_LW, 3'b010, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        for (int w = 0; w < 2; w++)
            cycleCheck($sformatf("lw_memread_wait%0d", w), T_LW, 3'b010, 1'b0, 1'b0, 1'b0,
                       ex(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cycleCheck("lw_memread", T_LW, 3'b010, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        cycleCheck("lw_memwb", T_LW, 3'b010, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // sw at zero wait states: 4 cycles
        cycleCheck("sw_fetch", T_SW, 3'b010, 1'b0, 1'b0, 1'b1, fetchOk(2'b01));
        cycleCheck("sw_decode", T_SW, 3'b010, 1'b0, 1'b0, 1'b1, decodeExp(2'b01));
        cycleCheck("sw_memadr", T_SW, 3'b010, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0));
        cycleCheck("sw_memwrite", T_SW, 3'b010, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));

        // beq taken then not taken (Zero high outside BEQ must not matter)
        cycleCheck("beqt_fetch", T_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, fetchOk(2'b10));
        cycleCheck("beqt_decode", T_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, decodeExp(2'b10));
        cycleCheck("beqt_beq", T_BEQ, 3'b000, 1'b0, 1'b1, 1'b1,
                   ex(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0));
        cycleCheck("beqn_fetch", T_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, fetchOk(2'b10));
        cycleCheck("beqn_decode", T_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(2'b10));
        cycleCheck("beqn_beq", T_BEQ, 3'b000, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0));

        // jal
        cycleCheck("jal_fetch", T_JAL, 3'b000, 1'b0, 1'b0, 1'b1, fetchOk(2'b11));
        cycleCheck("jal_decode", T_JAL, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(2'b11));
        cycleCheck("jal_jal", T_JAL, 3'b000, 1'b0, 1'b0, 1'b1,
                   ex(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0));
        cycleCheck("jal_wb", T_JAL, 3'b000, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b1));

        // sw stalled in MEMWRITE, then reset mid-write
        cycleCheck("swr_fetch", T_SW, 3'b010, 1'b0, 1'b0, 1'b1, fetchOk(2'b01));
        cycleCheck("swr_decode", T_SW, 3'b010, 1'b0, 1'b0, 1'b1, decodeExp(2'b01));
        cycleCheck("swr_memadr", T_SW, 3'b010, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0));
        cycleCheck("swr_memwrite_wait", T_SW, 3'b010, 1'b0, 1'b0, 1'b0,
                   ex(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));
        applyStimulus(T_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        checkOutput("swr_memwrite_hold", {16'h0, obs},
                    {16'h0, ex(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0)});
        reset = 1'b1;
        #1;
        checkOutput("swr_reset_drop", {16'h0, obs}, {16'h0, fetchWait(2'b01)});
        applyStimulus(T_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkOutput("swr_reset_ready_gated", {16'h0, obs}, {16'h0, fetchWait(2'b01)});
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycleCheck("post_reset_fetch", T_R, 3'b000, 1'b0, 1'b0, 1'b1, fetchOk(2'b00));
        cycleCheck("post_reset_decode", T_R, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(2'b00));
        cycleCheck("post_reset_exec", T_R, 3'b000, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0));
        cycleCheck("post_reset_wb", T_R, 3'b000, 1'b0, 1'b0, 1'b1,
                   ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

        // Unknown opcode
        cycleCheck("bad_fetch", T_BAD, 3'b000, 1'b0, 1'b0, 1'b1, fetchOk(2'b00));
        cycleCheck("bad_decode", T_BAD, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(2'b00));
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        for (int t = 0; t < 20; t++) begin
            applyStimulus(T_BAD, 3'b000, 1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("trap_illegal%0d", t), {31'h0, Illegal}, 32'h1);
            cycleCheck($sformatf("trap_ctrl%0d", t), T_BAD, 3'b000, 1'b0, 1'b1, 1'b1,
                       ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        end
        reset = 1'b1;
        #1;
        checkOutput("trap_reset_clear", {31'h0, Illegal}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycleCheck("trap_refetch", T_R, 3'b000, 1'b0, 1'b0, 1'b1, fetchOk(2'b00));
`else
        cycleCheck("bad_nop_fetch", T_R, 3'b000, 1'b0, 1'b0, 1'b1, fetchOk(2'b00));
        cycleCheck("bad_nop_decode", T_R, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(2'b00));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I-subset core. A Moore FSM with a small Mealy term sequences the shared datapath (one ALU, one unified memory port, instruction register, PC) through fetch, decode, execute, memory and writeback steps. It supports lw, sw, R-type ALU, I-type ALU, beq and jal. It stalls on a memory-ready handshake, so the same controller runs against both single-cycle and wait-stated memories.

## Interface
Parameters: none (encodings live in the package).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH immediately
- op  in  7  instruction opcode from the instruction register
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU result-is-zero flag
- MemReady  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register (and OldPC) enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (decoded from op, all states)
- ALUControl  out  3  ALU function
- RegWrite  out  1  register file write enable
- Illegal  out  1  only with MCCTRL_ILLEGAL_TRAP_EN; sticky illegal-opcode flag

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, JAL, ALUWB, BEQ (+TRAP under macro).
- Unlisted outputs are 0. ALUOp: 00 add, 01 sub, 10 funct-decoded.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=MemReady. Next state is DECODE if MemReady, otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target to ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - other → FETCH (treated as NOP)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until MemReady; then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- PCWrite = PCUpdate | (Branch & Zero).
- ALU decode:
  - ALUOp 00 → 000 (add); 01 → 001 (sub).
  - ALUOp 10, by funct3: 000 gives sub (001) when op[5]&funct7b5, else add (000); 010 → 101 slt; 110 → 011 or; 111 → 010 and; others → 000.

## Timing
- Reset asserted: state=FETCH asynchronously. PCWrite, IRWrite, MemWrite and RegWrite are forced 0 while reset is high, regardless of MemReady.
- First fetch can complete on the first rising edge after reset deassertion with MemReady=1.
- Cycles per instruction at zero wait states: lw 5, sw 4, R/I 4, jal 4, beq 3. Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Outputs are combinational from the registered state, except the MemReady gating in FETCH and the Zero term in PCWrite.
- Reset mid-instruction aborts it. Writes are suppressed from reset assertion onward, and no partial writeback occurs.

## Configuration
- MCCTRL_ILLEGAL_TRAP_EN defined:
  - An unknown op in DECODE, or funct3≠000 in BEQ-class, goes to TRAP.
  - TRAP asserts Illegal=1, keeps all enables 0 and never exits; only reset clears it.
- Not defined: no Illegal port, no TRAP state; unknown ops return to FETCH as NOP.

## Structure
- Package riscv_pkg holds:
  - opcode localparams
  - the state enum (typedef statetype)
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings
- One sub-module: the existing aludec, instantiated for the ALUOp/funct → ALUControl mapping. The FSM and the immediate decode stay in multicycle_controller.

## Test plan
- Reset mid-MEMWRITE with MemReady=0 → MemWrite drops to 0 immediately, and state is FETCH after deassertion.
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), MemReady=1 → 4 cycles, RegWrite=1 only in cycle 4, ALUControl=000 in EXECUTER.
- lw with MemReady low 2 cycles in MEMREAD → 7 cycles total, RegWrite with ResultSrc=01 in the final cycle only.
- beq with Zero=1 → PCWrite=1 in BEQ with ALUControl=001; with Zero=0, PCWrite stays 0 and the next fetch is from PC+4.
- jal → PCWrite=1 in JAL with ALUSrcA=01 and ALUSrcB=10; ALUWB writes with ResultSrc=00; ImmSrc=11 throughout.
- op 1111111 → returns to FETCH after DECODE without macro; with MCCTRL_ILLEGAL_TRAP_EN, Illegal=1 persists 20 cycles until reset.
